// File: rtl/lstm_cell_sequencer_pkg.sv
// Shared parameters, state encoding and fixed-point constants for the LSTM
// cell sequencer.
package lstm_seq_pkg;

    localparam int N    = 100;
    localparam int W    = 32;
    localparam int FRAC = 16;

    localparam int GA_W = $clog2(4 * N);
    localparam int CA_W = $clog2(N);

    localparam logic signed [W-1:0] ONE = {{(W-FRAC-1){1'b0}}, 1'b1, {FRAC{1'b0}}};

    localparam logic ACT_SIGMOID = 1'b0;
    localparam logic ACT_TANH    = 1'b1;

    localparam logic [2:0] P_LAST = 3'd6;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/lstm_cell_sequencer_if.sv
// Handshake, memory and activation-unit signals of the LSTM cell sequencer.
// master = sequencer side, slave = memories / activation unit / requester.
interface lstm_cell_sequencer_if;
    import lstm_seq_pkg::*;

    logic            start;
    logic            busy;
    logic            done;
    logic [GA_W-1:0] gate_addr;
    logic [W-1:0]    gate_rdata;
    logic [CA_W-1:0] c_addr;
    logic [W-1:0]    c_rdata;
    logic            c_we;
    logic [W-1:0]    c_wdata;
    logic [CA_W-1:0] h_addr;
    logic            h_we;
    logic [W-1:0]    h_wdata;
    logic            act_sel;
    logic [W-1:0]    act_x;
    logic [W-1:0]    act_y;

    modport master (
        input  start, gate_rdata, c_rdata, act_y,
        output busy, done, gate_addr, c_addr, c_we, c_wdata,
               h_addr, h_we, h_wdata, act_sel, act_x
    );

    modport slave (
        output start, gate_rdata, c_rdata, act_y,
        input  busy, done, gate_addr, c_addr, c_we, c_wdata,
               h_addr, h_we, h_wdata, act_sel, act_x
    );

endinterface

// File: rtl/lstm_cell_sequencer_fx_sat_mac.sv
// Combinational saturating Q15.16 multiply and multiply-accumulate:
// mul_y = sat_mul(a,b), mac_y = sat_add(sat_mul(a,b), sat_mul(c,e)).
module fx_sat_mac
    import lstm_seq_pkg::*;
(
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    input  logic [W-1:0] e,
    output logic [W-1:0] mac_y,
    output logic [W-1:0] mul_y
);

    localparam logic signed [W-1:0] SMAX = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};

    function automatic logic [W-1:0] sat_mul(input logic [W-1:0] x, input logic [W-1:0] y);
        logic signed [2*W-1:0] xs;
        logic signed [2*W-1:0] ys;
        logic signed [2*W-1:0] prod;
        xs   = (2*W)'($signed(x));
        ys   = (2*W)'($signed(y));
        prod = (xs * ys) >>> FRAC;
        if (prod > (2*W)'(SMAX)) begin
            sat_mul = SMAX;
        end else if (prod < (2*W)'(SMIN)) begin
            sat_mul = SMIN;
        end else begin
            sat_mul = prod[W-1:0];
        end
    endfunction

    function automatic logic [W-1:0] sat_add(input logic [W-1:0] x, input logic [W-1:0] y);
        logic signed [W:0] s;
        s = (W+1)'($signed(x)) + (W+1)'($signed(y));
        if (s > (W+1)'(SMAX)) begin
            sat_add = SMAX;
        end else if (s < (W+1)'(SMIN)) begin
            sat_add = SMIN;
        end else begin
            sat_add = s[W-1:0];
        end
    endfunction

    logic [W-1:0] ab;
    logic [W-1:0] ce;

    assign ab    = sat_mul(a, b);
    assign ce    = sat_mul(c, e);
    assign mul_y = ab;
    assign mac_y = sat_add(ab, ce);

endmodule

// File: rtl/lstm_cell_sequencer.sv
// Element-serial LSTM cell update: seven single-cycle phases per element,
// sharing one activation unit and one saturating MAC.
//
// state  | meaning
// S_IDLE | waiting for start
// S_RUN  | element k, phase p (0..6)
// S_DONE | one-cycle completion pulse, then back to idle
module lstm_cell_sequencer
    import lstm_seq_pkg::*;
(
    input logic                   clk,
    input logic                   rst_n,
    lstm_cell_sequencer_if.master bus
);

    state_e          state_q, state_d;
    logic [2:0]      p_q, p_d;
    logic [CA_W-1:0] k_q, k_d;

    logic [W-1:0] f_q, f_d;
    logic [W-1:0] cp_q, cp_d;
    logic [W-1:0] g_q, g_d;
    logic [W-1:0] i_q, i_d;
    logic [W-1:0] o_q, o_d;
    logic [W-1:0] cn_q, cn_d;
    logic [W-1:0] d_q, d_d;

    logic [GA_W-1:0] gate_addr_q, gate_addr_d;
    logic [CA_W-1:0] c_addr_q, c_addr_d;
    logic [CA_W-1:0] h_addr_q, h_addr_d;
    logic [W-1:0]    c_wdata_q, c_wdata_d;
    logic [W-1:0]    h_wdata_q, h_wdata_d;
    logic            act_sel_q, act_sel_d;

    logic [W-1:0]    act_x_o;
    logic            c_we_o;
    logic            h_we_o;

    logic            run;
    logic            last_k;
    logic [GA_W-1:0] k_ext;
    logic [W-1:0]    mac_a, mac_b, mac_y, mul_y;

    assign run    = (state_q == S_RUN);
    assign last_k = (k_q == CA_W'(N - 1));
    assign k_ext  = GA_W'(k_q);

    // The single multiplier pair serves f*cp in p4 and o*d in p6.
    assign mac_a = (p_q == P_LAST) ? o_q : f_q;
    assign mac_b = (p_q == P_LAST) ? d_q : cp_q;

    fx_sat_mac u_mac (
        .a     (mac_a),
        .b     (mac_b),
        .c     (g_q),
        .e     (i_q),
        .mac_y (mac_y),
        .mul_y (mul_y)
    );

    // Phase-driven outputs; anything a phase does not drive holds its last value.
    always_comb begin
        gate_addr_d = gate_addr_q;
        c_addr_d    = c_addr_q;
        h_addr_d    = h_addr_q;
        c_wdata_d   = c_wdata_q;
        h_wdata_d   = h_wdata_q;
        act_sel_d   = act_sel_q;
        act_x_o     = '0;
        c_we_o      = 1'b0;
        h_we_o      = 1'b0;
        if (run) begin
            case (p_q)
                3'd0: begin
                    gate_addr_d = k_ext;
                    c_addr_d    = k_q;
                end
                3'd1: begin
                    gate_addr_d = k_ext + GA_W'(N);
                    act_sel_d   = ACT_SIGMOID;
                    act_x_o     = bus.gate_rdata;
                end
                3'd2: begin
                    gate_addr_d = k_ext + GA_W'(2 * N);
                    act_sel_d   = ACT_TANH;
                    act_x_o     = bus.gate_rdata;
                end
                3'd3: begin
                    gate_addr_d = k_ext + GA_W'(3 * N);
                    act_sel_d   = ACT_SIGMOID;
                    act_x_o     = bus.gate_rdata;
                end
                3'd4: begin
                    act_sel_d = ACT_SIGMOID;
                    act_x_o   = bus.gate_rdata;
                end
                3'd5: begin
                    act_sel_d = ACT_TANH;
                    act_x_o   = cn_q;
                    c_we_o    = 1'b1;
                    c_addr_d  = k_q;
                    c_wdata_d = cn_q;
                end
                3'd6: begin
                    h_we_o    = 1'b1;
                    h_addr_d  = k_q;
                    h_wdata_d = mul_y;
                end
                default: ;
            endcase
        end
    end

    // Next state and operand latches. Kept apart from the block above so the
    // act_x -> act_y -> latch path is not a loop through one process.
    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        k_d     = k_q;
        f_d     = f_q;
        cp_d    = cp_q;
        g_d     = g_q;
        i_d     = i_q;
        o_d     = o_q;
        cn_d    = cn_q;
        d_d     = d_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_RUN;
                    p_d     = '0;
                    k_d     = '0;
                end
            end
            S_RUN: begin
                case (p_q)
                    3'd1: begin
                        f_d  = bus.act_y;
                        cp_d = bus.c_rdata;
                    end
                    3'd2: g_d = bus.act_y;
                    3'd3: i_d = bus.act_y;
                    3'd4: begin
                        o_d  = bus.act_y;
                        cn_d = mac_y;
                    end
                    3'd5: d_d = bus.act_y;
                    default: ;
                endcase
                if (p_q == P_LAST) begin
                    p_d = '0;
                    if (last_k) begin
                        state_d = S_DONE;
                        k_d     = '0;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end else begin
                    p_d = p_q + 3'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            p_q     <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            k_q     <= k_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_q         <= '0;
            cp_q        <= '0;
            g_q         <= '0;
            i_q         <= '0;
            o_q         <= '0;
            cn_q        <= '0;
            d_q         <= '0;
            gate_addr_q <= '0;
            c_addr_q    <= '0;
            h_addr_q    <= '0;
            c_wdata_q   <= '0;
            h_wdata_q   <= '0;
            act_sel_q   <= ACT_SIGMOID;
        end else begin
            f_q         <= f_d;
            cp_q        <= cp_d;
            g_q         <= g_d;
            i_q         <= i_d;
            o_q         <= o_d;
            cn_q        <= cn_d;
            d_q         <= d_d;
            gate_addr_q <= gate_addr_d;
            c_addr_q    <= c_addr_d;
            h_addr_q    <= h_addr_d;
            c_wdata_q   <= c_wdata_d;
            h_wdata_q   <= h_wdata_d;
            act_sel_q   <= act_sel_d;
        end
    end

    assign bus.busy      = run;
    assign bus.done      = (state_q == S_DONE);
    assign bus.gate_addr = gate_addr_d;
    assign bus.c_addr    = c_addr_d;
    assign bus.c_we      = c_we_o;
    assign bus.c_wdata   = c_wdata_d;
    assign bus.h_addr    = h_addr_d;
    assign bus.h_we      = h_we_o;
    assign bus.h_wdata   = h_wdata_d;
    assign bus.act_sel   = act_sel_d;
    assign bus.act_x     = act_x_o;

endmodule

// File: tb/tb_lstm_cell_sequencer.sv
// Self-checking bench: memories and activation unit around the sequencer,
// with a per-element arithmetic reference for c_next and h_t.
module tb_lstm_cell_sequencer;
    import lstm_seq_pkg::*;

    localparam longint MAXL = 64'sd2147483647;
    localparam longint MINL = -64'sd2147483648;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    lstm_cell_sequencer_if bus();

    lstm_cell_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [W-1:0] gate_mem [4*N];
    logic [W-1:0] c_mem    [N];
    logic [W-1:0] c_init   [N];
    logic [W-1:0] exp_c    [N];
    logic [W-1:0] exp_h    [N];
    logic         load_c;
    bit           real_act;

    int           total = 0;
    int           bad   = 0;

    int           cl_addr[$];
    logic [W-1:0] cl_data[$];
    int           hl_addr[$];
    logic [W-1:0] hl_data[$];
    int           hl_cyc[$];

    // Activation unit: identity, or hard sigmoid / hard tanh.
    function automatic logic [W-1:0] act_model(input logic sel, input logic [W-1:0] x, input bit use_real);
        longint xv, y, lo;
        if (!use_real) return x;
        xv = longint'($signed(x));
        if (sel == ACT_SIGMOID) begin
            y  = xv / 4 + longint'(ONE) / 2;
            lo = 0;
        end else begin
            y  = xv;
            lo = -longint'(ONE);
        end
        if (y > longint'(ONE)) y = longint'(ONE);
        if (y < lo) y = lo;
        return W'(y);
    endfunction

    assign bus.act_y = act_model(bus.act_sel, bus.act_x, real_act);

    always @(posedge clk) begin
        bus.gate_rdata <= gate_mem[bus.gate_addr];
        bus.c_rdata    <= c_mem[bus.c_addr];
        if (load_c) begin
            for (int j = 0; j < N; j++) c_mem[j] <= c_init[j];
        end else if (bus.c_we) begin
            c_mem[bus.c_addr] <= bus.c_wdata;
        end
    end

    function automatic longint clamp32(input longint v);
        if (v > MAXL) return MAXL;
        if (v < MINL) return MINL;
        return v;
    endfunction

    function automatic logic [W-1:0] fx_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return W'(clamp32(p >>> FRAC));
    endfunction

    function automatic logic [W-1:0] fx_add(input logic [W-1:0] a, input logic [W-1:0] b);
        return W'(clamp32(longint'($signed(a)) + longint'($signed(b))));
    endfunction

    function automatic logic [W-1:0] rnd_q();
        logic [W-1:0] v;
        if ($urandom_range(0, 3) == 0) return $urandom();
        v = $urandom_range(0, 32'h000C_0000);
        return v - 32'h0006_0000;
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},      W'(bus.busy),      '0);
        check({tag, "_done"},      W'(bus.done),      '0);
        check({tag, "_c_we"},      W'(bus.c_we),      '0);
        check({tag, "_h_we"},      W'(bus.h_we),      '0);
        check({tag, "_gate_addr"}, W'(bus.gate_addr), '0);
        check({tag, "_c_addr"},    W'(bus.c_addr),    '0);
        check({tag, "_h_addr"},    W'(bus.h_addr),    '0);
        check({tag, "_c_wdata"},   bus.c_wdata,       '0);
        check({tag, "_h_wdata"},   bus.h_wdata,       '0);
        check({tag, "_act_x"},     bus.act_x,         '0);
        check({tag, "_act_sel"},   W'(bus.act_sel),   '0);
    endtask

    task automatic fill(input bit directed, input bit load);
        for (int j = 0; j < 4*N; j++) gate_mem[j] = rnd_q();
        for (int j = 0; j < N; j++) c_init[j] = rnd_q();
        if (directed) begin
            gate_mem[0] = 32'h0000_8000; gate_mem[N]   = 32'h0001_0000;
            gate_mem[2*N] = 32'h0000_4000; gate_mem[3*N] = 32'h0000_8000;
            c_init[0] = 32'h0002_0000;
            gate_mem[1] = 32'h7FFF_0000; gate_mem[N+1] = '0; gate_mem[2*N+1] = '0;
            c_init[1] = 32'h0002_0000;
            gate_mem[2] = 32'h8000_0000; gate_mem[N+2] = '0; gate_mem[2*N+2] = '0;
            c_init[2] = 32'h0002_0000;
            gate_mem[3] = 32'hFFFF_0000; gate_mem[N+3] = '0; gate_mem[2*N+3] = '0;
            gate_mem[3*N+3] = 32'h0001_0000;
            c_init[3] = 32'h0000_8000;
        end
        if (load) begin
            @(negedge clk); load_c = 1'b1;
            @(negedge clk); load_c = 1'b0;
        end
    endtask

    task automatic build_golden();
        logic [W-1:0] f, g, i, o, cn, d;
        for (int k = 0; k < N; k++) begin
            f  = act_model(ACT_SIGMOID, gate_mem[k],       real_act);
            g  = act_model(ACT_TANH,    gate_mem[N+k],     real_act);
            i  = act_model(ACT_SIGMOID, gate_mem[2*N+k],   real_act);
            o  = act_model(ACT_SIGMOID, gate_mem[3*N+k],   real_act);
            cn = fx_add(fx_mul(f, c_mem[k]), fx_mul(g, i));
            d  = act_model(ACT_TANH, cn, real_act);
            exp_c[k] = cn;
            exp_h[k] = fx_mul(o, d);
        end
    endtask

    task automatic check_logs(input string tag, input int count);
        check({tag, "_c_count"}, W'(cl_addr.size()), W'(count));
        check({tag, "_h_count"}, W'(hl_addr.size()), W'(count));
        for (int k = 0; k < count && k < cl_addr.size() && k < hl_addr.size(); k++) begin
            check($sformatf("%s_c_addr[%0d]", tag, k), W'(cl_addr[k]), W'(k));
            check($sformatf("%s_c_data[%0d]", tag, k), cl_data[k], exp_c[k]);
            check($sformatf("%s_h_addr[%0d]", tag, k), W'(hl_addr[k]), W'(k));
            check($sformatf("%s_h_data[%0d]", tag, k), hl_data[k], exp_h[k]);
            check($sformatf("%s_h_cycle[%0d]", tag, k), W'(hl_cyc[k]), W'(7*k + 7));
        end
    endtask

    // Cycle 1 is the cycle right after the edge that samples start (phase 0 of k=0).
    task automatic run_pass(input string tag, input int rst_at, input bit poke);
        int  done_cyc, busy_bad, act_bad, ph, strobes;
        logic exp_sel [7];
        exp_sel = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        cl_addr.delete(); cl_data.delete();
        hl_addr.delete(); hl_data.delete(); hl_cyc.delete();
        build_golden();
        done_cyc = 0; busy_bad = 0; act_bad = 0;
        @(negedge clk); bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        for (int cyc = 1; cyc <= 760; cyc++) begin
            @(negedge clk);
            if (bus.c_we) begin cl_addr.push_back(int'(bus.c_addr)); cl_data.push_back(bus.c_wdata); end
            if (bus.h_we) begin
                hl_addr.push_back(int'(bus.h_addr)); hl_data.push_back(bus.h_wdata); hl_cyc.push_back(cyc);
            end
            ph = (cyc - 1) % 7;
            if (bus.busy && ph >= 1 && ph <= 5 && bus.act_sel !== exp_sel[ph]) act_bad++;
            if (bus.busy && (ph == 0 || ph == 6) && bus.act_x !== '0) act_bad++;
            if (bus.done) begin
                done_cyc = cyc;
                if (bus.busy) busy_bad++;
                break;
            end
            if (!bus.busy) busy_bad++;
            bus.start = poke && (cyc == 50 || cyc == 400);
            if (rst_at == cyc) begin
                rst_n = 1'b0;
                break;
            end
        end
        bus.start = 1'b0;
        check({tag, "_busy_profile"}, W'(busy_bad), '0);
        check({tag, "_act_sel_x_profile"}, W'(act_bad), '0);
        if (rst_at == 0) begin
            check({tag, "_done_cycle"}, W'(done_cyc), W'(7*N + 1));
            check_logs(tag, N);
            if (poke) bus.start = 1'b1;
            @(posedge clk); #1 bus.start = 1'b0;
            @(negedge clk);
            check({tag, "_idle_busy"}, W'(bus.busy), '0);
            check({tag, "_idle_done"}, W'(bus.done), '0);
            for (int k = 0; k < N; k++) check($sformatf("%s_c_mem[%0d]", tag, k), c_mem[k], exp_c[k]);
        end else begin
            #1;
            check_reset_outputs({tag, "_rst"});
            check_logs(tag, rst_at / 7);
            strobes = 0;
            repeat (5) begin @(negedge clk); strobes += int'(bus.c_we) + int'(bus.h_we) + int'(bus.busy); end
            rst_n = 1'b1;
            repeat (3) begin @(negedge clk); strobes += int'(bus.c_we) + int'(bus.h_we) + int'(bus.busy); end
            check({tag, "_after_rst_activity"}, W'(strobes), '0);
        end
    endtask

    initial begin
        bus.start = 1'b0;
        real_act  = 1'b0;
        load_c    = 1'b0;
        rst_n     = 1'b1;
        #1 rst_n  = 1'b0;
        #2;
        check_reset_outputs("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        fill(1'b1, 1'b1);
        run_pass("runA", 0, 1'b1);
        check("k0_c_wdata", cl_data[0], 32'h0001_4000);
        check("k0_h_wdata", hl_data[0], 32'h0000_A000);
        check("k1_c_sat_pos", cl_data[1], 32'h7FFF_FFFF);
        check("k2_c_sat_neg", cl_data[2], 32'h8000_0000);
        check("k3_c_wdata", cl_data[3], 32'hFFFF_8000);
        check("k3_h_wdata", hl_data[3], 32'hFFFF_8000);

        real_act = 1'b1;
        fill(1'b0, 1'b1);
        run_pass("runB", 1 + 7*37 + 3, 1'b0);

        fill(1'b0, 1'b0);
        repeat (2) @(negedge clk);
        run_pass("runC", 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lstm_cell_sequencer.md
# lstm_cell_sequencer

- Sequential controller that evaluates one LSTM cell update (c_next, h_t) element by element.
- Time-shares a single external activation unit (sigmoid/tanh) and one saturating fixed-point MAC, instead of 100-lane combinational datapaths.
- Sits between the gate pre-activation buffer (f,g,i,o, 4N words), the cell-state memory, and the hidden-state memory.
- Runs one timestep per start pulse.

## Interface

Parameters:
- N, 100, vector length (elements per gate)
- W, 32, data width, signed
- FRAC, 16, fractional bits (Q15.16 fixed point; 1.0 = 0x00010000)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  request one timestep; accepted only in IDLE
- busy  out  1  high from acceptance until done
- done  out  1  single-cycle pulse when the last h_t word is written
- gate_addr  out  $clog2(4N)  pre-activation read address (f at k, g at N+k, i at 2N+k, o at 3N+k)
- gate_rdata  in  W  pre-activation data, valid one cycle after gate_addr
- c_addr  out  $clog2(N)  cell-state address (read and write)
- c_rdata  in  W  c_prev[k], valid one cycle after c_addr
- c_we  out  1  cell-state write strobe
- c_wdata  out  W  c_next[k]
- h_addr  out  $clog2(N)  hidden-state write address
- h_we  out  1  hidden-state write strobe
- h_wdata  out  W  h_t[k]
- act_sel  out  1  0 = sigmoid, 1 = tanh
- act_x  out  W  activation unit input
- act_y  in  W  activation unit output, combinational from act_x (same cycle)

## Operation

- States: IDLE, RUN (phase counter p = 0..6, element counter k = 0..N-1), DONE.
- IDLE -> RUN on start. RUN -> DONE after p = 6 of k = N-1. DONE -> IDLE unconditionally after 1 cycle.
- Phase schedule for element k, one cycle per phase:
  - p0: gate_addr = k; c_addr = k.
  - p1: gate_addr = N+k. act_sel = 0, act_x = gate_rdata; latch f = act_y; latch cp = c_rdata.
  - p2: gate_addr = 2N+k. act_sel = 1, act_x = gate_rdata; latch g.
  - p3: gate_addr = 3N+k. act_sel = 0; latch i.
  - p4: act_sel = 0, act_x = gate_rdata; latch o. Latch cn = sat_add(sat_mul(f,cp), sat_mul(g,i)).
  - p5: act_sel = 1, act_x = cn; latch d = act_y. c_we = 1, c_addr = k, c_wdata = cn.
  - p6: h_we = 1, h_addr = k, h_wdata = sat_mul(o,d). Then k += 1 and p = 0 (or go to DONE).
- In p4, cn uses the f, cp and g latched in p1-p2, the i latched in p3, and the current-cycle act_y is not involved.
- sat_mul(a,b):
  - full 2W-bit signed product, then arithmetic shift right by FRAC;
  - clamp to [-2^(W-1), 2^(W-1)-1].
- sat_add: W+1-bit signed sum, clamped the same way.
- In-place update is legal: the c memory may alias c_prev and c_next. Element k is read in p0 and written in p5; no other element is touched in between.
- Outputs undriven by the current phase: strobes 0, addresses/data hold the last value, act_x = 0.

## Timing

- Reset values: busy = 0, done = 0, c_we = 0, h_we = 0, all addresses 0, c_wdata = h_wdata = act_x = 0, act_sel = 0, state IDLE, k = p = 0.
- start sampled high in IDLE at edge T:
  - busy = 1 from T;
  - first p0 in cycle T+1;
  - h_we for element k in cycle T+1+7k+6;
  - done = 1 for exactly one cycle at T+1+7N (T+701 for N = 100), with busy = 0 in that same cycle.
- start while busy or in DONE: ignored, not queued.
- rst_n asserted mid-run: immediate return to IDLE with all outputs at reset values. No write strobe may complete after reset assertion. A partially updated c memory is the requester's responsibility.
- Exactly N c writes and N h writes per run, at ascending addresses.

## Structure

- Package lstm_seq_pkg holds:
  - N, W, FRAC;
  - the state enum (IDLE, RUN, DONE) and the ACT_SIGMOID/ACT_TANH encoding;
  - the Q15.16 constant ONE.
- Sub-module fx_sat_mac (combinational) contains sat_mul and sat_add, computing sat_add(sat_mul(a,b), sat_mul(c,e)) and sat_mul(a,b). The sequencer instantiates it once.
- Activation unit, gate buffer and state memories are external.

## Test plan

All scenarios use a bench activation model set to identity (act_y = act_x) unless stated.

- f = 0x8000, c_prev = 0x20000, g = 0x10000, i = 0x4000, o = 0x8000 at k = 0 -> c_wdata = 0x14000, h_wdata = 0xA000.
- f = 0x7FFF0000, c_prev = 0x20000, g = i = 0 -> c_wdata = 0x7FFFFFFF. f = 0x80000000, same c_prev -> 0x80000000.
- f = 0xFFFF0000 (-1.0), c_prev = 0x8000, g = i = 0, o = 0x10000 -> c_wdata = h_wdata = 0xFFFF8000.
- start at T with N = 100:
  - 100 c writes and 100 h writes, addresses 0..99 ascending;
  - done only at T+701;
  - second start pulses during busy are ignored;
  - act_sel sequence per element is 0,1,0,0,1.
- rst_n low at element 37, p3 -> no further c_we/h_we; outputs at reset values. A new start runs a full 701-cycle pass.
- Aliased c memory with real sigmoid/tanh models and random Q15.16 vectors -> c and h match a per-element golden model bit-exactly.
